// File: rtl/bp_fe_pkg.sv
// Shared configuration, fill-sequencer states and packet payloads for the FE I-cache.
package bp_fe_pkg;

  localparam int unsigned paddr_width_p = 40;
  localparam int unsigned sets_p        = 64;
  localparam int unsigned assoc_p       = 8;
  localparam int unsigned block_width_p = 512;
  localparam int unsigned fill_width_p  = 64;

  localparam int unsigned fill_beats_lp = block_width_p / fill_width_p;
  localparam int unsigned offset_w_lp   = $clog2(block_width_p / 8);
  localparam int unsigned index_w_lp    = $clog2(sets_p);
  localparam int unsigned ptag_w_lp     = paddr_width_p - offset_w_lp - index_w_lp;
  localparam int unsigned way_w_lp      = (assoc_p > 1) ? $clog2(assoc_p) : 1;
  localparam int unsigned beat_w_lp     = (fill_beats_lp > 1) ? $clog2(fill_beats_lp) : 1;
  localparam int unsigned word_off_w_lp = $clog2(fill_width_p / 8);

  typedef enum logic [2:0] {
    e_ready = 3'd0,
    e_send  = 3'd1,
    e_fill  = 3'd2,
    e_tag   = 3'd3,
    e_stat  = 3'd4,
    e_done  = 3'd5
  } bp_fe_fill_state_e;

  typedef struct packed {
    logic [index_w_lp-1:0]   index;
    logic [way_w_lp-1:0]     way;
    logic [beat_w_lp-1:0]    beat;
    logic [fill_width_p-1:0] data;
  } bp_fe_icache_data_pkt_s;

  typedef struct packed {
    logic [index_w_lp-1:0] index;
    logic [way_w_lp-1:0]   way;
    logic [ptag_w_lp-1:0]  tag;
  } bp_fe_icache_tag_pkt_s;

  typedef struct packed {
    logic [index_w_lp-1:0] index;
    logic [way_w_lp-1:0]   way;
  } bp_fe_icache_stat_pkt_s;

endpackage

// File: rtl/bp_fe_icache_fill_ctrl_counter.sv
// Wrapping up-counter with synchronous clear; counts refill beats that have been written.
module bsg_counter_clear_up #(
  parameter int unsigned max_val_p = 7,
  parameter int unsigned width_p   = 3
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o
);

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i)
      count_o <= '0;
    else if (up_i)
      count_o <= (count_o == width_p'(max_val_p)) ? '0 : count_o + width_p'(1);
  end

endmodule

// File: rtl/bp_fe_icache_fill_ctrl.sv
// I-cache miss refill sequencer: one block read, critical-first beat writes, then tag, then stat/LRU.
module bp_fe_icache_fill_ctrl
  import bp_fe_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     reset_i,

  input  logic [paddr_width_p-1:0] cache_req_addr_i,
  input  logic                     cache_req_v_i,
  output logic                     cache_req_ready_o,
  input  logic [way_w_lp-1:0]      cache_req_way_i,
  input  logic                     cache_req_metadata_v_i,
  output logic                     cache_req_critical_o,
  output logic                     cache_req_complete_o,

  output logic [paddr_width_p-1:0] mem_cmd_addr_o,
  output logic                     mem_cmd_v_o,
  input  logic                     mem_cmd_ready_i,

  input  logic [fill_width_p-1:0]  mem_resp_data_i,
  input  logic                     mem_resp_v_i,
  output logic                     mem_resp_yumi_o,

  output logic [index_w_lp-1:0]    data_pkt_index_o,
  output logic [way_w_lp-1:0]      data_pkt_way_o,
  output logic [beat_w_lp-1:0]     data_pkt_beat_o,
  output logic [fill_width_p-1:0]  data_pkt_data_o,
  output logic                     data_pkt_v_o,
  input  logic                     data_pkt_ready_i,

  output logic [index_w_lp-1:0]    tag_pkt_index_o,
  output logic [way_w_lp-1:0]      tag_pkt_way_o,
  output logic [ptag_w_lp-1:0]     tag_pkt_tag_o,
  output logic                     tag_pkt_v_o,
  input  logic                     tag_pkt_ready_i,

  output logic [index_w_lp-1:0]    stat_pkt_index_o,
  output logic [way_w_lp-1:0]      stat_pkt_way_o,
  output logic                     stat_pkt_v_o,
  input  logic                     stat_pkt_ready_i
);

  bp_fe_fill_state_e state, state_n;

  logic [paddr_width_p-1:0] addr_r;
  logic [way_w_lp-1:0]      way_r;
  logic                     way_v_r, cmd_done_r, critical_r;
  logic [beat_w_lp-1:0]     beat_cnt, start_beat, beat_c;
  logic [index_w_lp-1:0]    index_c;
  logic                     fill_start, last_beat;

  bp_fe_icache_data_pkt_s data_pkt;
  bp_fe_icache_tag_pkt_s  tag_pkt;
  bp_fe_icache_stat_pkt_s stat_pkt;

  assign index_c    = addr_r[offset_w_lp +: index_w_lp];
  assign start_beat = (fill_beats_lp > 1) ? addr_r[word_off_w_lp +: beat_w_lp] : '0;
  assign beat_c     = start_beat + beat_cnt;
  assign last_beat  = (beat_cnt == beat_w_lp'(fill_beats_lp - 1));

  always_ff @(posedge clk_i) begin
    if (reset_i)
      state <= e_ready;
    else
      state <= state_n;
  end

  // Next state and handshake decode; everything is forced quiet while reset is held.
  always_comb begin
    state_n              = state;
    cache_req_ready_o    = 1'b0;
    mem_cmd_v_o          = 1'b0;
    data_pkt_v_o         = 1'b0;
    mem_resp_yumi_o      = 1'b0;
    tag_pkt_v_o          = 1'b0;
    stat_pkt_v_o         = 1'b0;
    cache_req_complete_o = 1'b0;
    fill_start           = 1'b0;
    case (state)
      e_ready: begin
        cache_req_ready_o = 1'b1;
        if (cache_req_v_i) state_n = e_send;
      end
      e_send: begin
        mem_cmd_v_o = ~cmd_done_r;
        if ((cmd_done_r || mem_cmd_ready_i) && (way_v_r || cache_req_metadata_v_i)) begin
          state_n    = e_fill;
          fill_start = 1'b1;
        end
      end
      e_fill: begin
        data_pkt_v_o    = mem_resp_v_i;
        mem_resp_yumi_o = mem_resp_v_i && data_pkt_ready_i;
        if (mem_resp_yumi_o && last_beat) state_n = e_tag;
      end
      e_tag: begin
        tag_pkt_v_o = 1'b1;
        if (tag_pkt_ready_i) state_n = e_stat;
      end
      e_stat: begin
        stat_pkt_v_o = 1'b1;
        if (stat_pkt_ready_i) state_n = e_done;
      end
      e_done: begin
        cache_req_complete_o = 1'b1;
        state_n              = e_ready;
      end
      default: state_n = e_ready;
    endcase
    if (reset_i) begin
      cache_req_ready_o    = 1'b0;
      mem_cmd_v_o          = 1'b0;
      data_pkt_v_o         = 1'b0;
      mem_resp_yumi_o      = 1'b0;
      tag_pkt_v_o          = 1'b0;
      stat_pkt_v_o         = 1'b0;
      cache_req_complete_o = 1'b0;
      fill_start           = 1'b0;
    end
  end

  // Miss context: address on accept, victim way at most once per miss, command-sent flag.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      addr_r     <= '0;
      way_r      <= '0;
      way_v_r    <= 1'b0;
      cmd_done_r <= 1'b0;
      critical_r <= 1'b0;
    end else begin
      critical_r <= mem_resp_yumi_o && (beat_cnt == '0);
      if (cache_req_ready_o && cache_req_v_i) begin
        addr_r     <= cache_req_addr_i;
        way_v_r    <= cache_req_metadata_v_i;
        cmd_done_r <= 1'b0;
        if (cache_req_metadata_v_i) way_r <= cache_req_way_i;
      end
      if (state == e_send) begin
        if (cache_req_metadata_v_i && !way_v_r) begin
          way_r   <= cache_req_way_i;
          way_v_r <= 1'b1;
        end
        if (mem_cmd_v_o && mem_cmd_ready_i) cmd_done_r <= 1'b1;
      end
    end
  end

  bsg_counter_clear_up #(
    .max_val_p (fill_beats_lp - 1),
    .width_p   (beat_w_lp)
  ) beat_counter (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (fill_start),
    .up_i    (mem_resp_yumi_o),
    .count_o (beat_cnt)
  );

  assign data_pkt = '{index: index_c, way: way_r, beat: beat_c, data: mem_resp_data_i};
  assign tag_pkt  = '{index: index_c, way: way_r, tag: addr_r[paddr_width_p-1 -: ptag_w_lp]};
  assign stat_pkt = '{index: index_c, way: way_r};

  assign cache_req_critical_o = critical_r;
  assign mem_cmd_addr_o       = addr_r;

  assign data_pkt_index_o = data_pkt.index;
  assign data_pkt_way_o   = data_pkt.way;
  assign data_pkt_beat_o  = data_pkt.beat;
  assign data_pkt_data_o  = data_pkt.data;
  assign tag_pkt_index_o  = tag_pkt.index;
  assign tag_pkt_way_o    = tag_pkt.way;
  assign tag_pkt_tag_o    = tag_pkt.tag;
  assign stat_pkt_index_o = stat_pkt.index;
  assign stat_pkt_way_o   = stat_pkt.way;

endmodule
